// File: rtl/cacheline_arbiter_if.sv
// Bus bundle between the I/D cache miss handlers, the cacheline arbiter and
// the single burst memory port.
//   slave  : view taken by the arbiter (it serves the caches, commands memory)
//   master : view taken by the surrounding caches and memory model
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              busy;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output busy
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  busy
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Two-requester arbiter sharing one physical-memory cacheline port between
// the I-cache and D-cache miss handlers.
//
// Build option: define ARB_RR_EN for round-robin tie-breaking; without it a
// simultaneous request is always granted to the D-cache (a D miss is older
// in program order than an I miss).
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no grant; pmem_* held at 0
// GNT_I | I-cache owns the memory port until pmem_resp
// GNT_D | D-cache owns the memory port until pmem_resp
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  cacheline_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [LINE_W-1:0] ZERO_LINE = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_RR_EN
  // 1 when the D-cache received the most recent grant
  logic last_d;
  assign pick_d = ~last_d;
`else
  assign pick_d = 1'b1;
`endif

  // Grant FSM: arbitrate only from IDLE, release on the memory completion edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
`ifdef ARB_RR_EN
      last_d <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_req && (!i_req || pick_d)) begin
            state    <= GNT_D;
            bus.busy <= 1'b1;
`ifdef ARB_RR_EN
            last_d   <= 1'b1;
`endif
          end else if (i_req) begin
            state    <= GNT_I;
            bus.busy <= 1'b1;
`ifdef ARB_RR_EN
            last_d   <= 1'b0;
`endif
          end
        end
        GNT_I, GNT_D: begin
          // the forced IDLE cycle afterwards lets the requester drop its request
          if (bus.pmem_resp) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Steer the owner's command to memory and the completion back to the owner
  always_comb begin
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_addr  = ZERO_ADDR;
    bus.pmem_wdata = ZERO_LINE;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;
    case (state)
      GNT_I: begin
        bus.pmem_read = 1'b1;
        bus.pmem_addr = bus.i_addr;
        bus.i_resp    = bus.pmem_resp;
      end
      GNT_D: begin
        // a writeback beats a read if both are raised together
        bus.pmem_read  = bus.d_read & ~bus.d_write;
        bus.pmem_write = bus.d_write;
        bus.pmem_addr  = bus.d_addr;
        bus.pmem_wdata = bus.d_wdata;
        bus.d_resp     = bus.pmem_resp;
      end
      default: begin
      end
    endcase
  end

  // Read data fans out to both caches; only the resp pulse is qualified
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: directed scenarios plus a
// randomized phase, checked every cycle against a transaction-level model.
module tb_cacheline_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cacheline_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } dop_t;

  typedef struct {
    int            who;   // 0 = I, 1 = D
    bit            wr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } rsp_t;

  logic [AW-1:0] i_q[$];
  dop_t          d_q[$];
  rsp_t          rsp_log[$];
  int            grant_log[$];   // model grants: 1 = I, 2 = D
  logic [LW-1:0] mem [logic [AW-1:0]];

  int tests = 0;
  int fails = 0;

  // behavioural model: who owns the port (0 none, 1 I, 2 D), who was served last
  int owner = 0;
  bit last_d = 1'b0;

  // memory model state
  bit            mem_pend = 1'b0;
  int            mem_cnt = 0;
  bit            lat_rand = 1'b0;
  int            stray_n = 0;
  logic [AW-1:0] mem_addr;
  bit            mem_wr;
  logic [LW-1:0] mem_wdata;

  // samples taken at the negative edge
  bit            s_i, s_d, s_cmd, s_wr;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_wdata;
  int            n_pread = 0;
  int            n_iresp = 0;
  int            n_dresp = 0;

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no response, expected one", name);
  endtask

  // compare DUT outputs against what the model says the owner must see
  task automatic compare();
    logic          er, ew, eir, edr, eb;
    logic [AW-1:0] ea;
    logic [LW-1:0] ed;
    er = 1'b0; ew = 1'b0; eir = 1'b0; edr = 1'b0; eb = 1'b0;
    ea = '0; ed = '0;
    if (owner == 1) begin
      er = 1'b1; ea = bus.i_addr; eir = bus.pmem_resp; eb = 1'b1;
    end else if (owner == 2) begin
      ew = bus.d_write; er = bus.d_read && !bus.d_write;
      ea = bus.d_addr; ed = bus.d_wdata; edr = bus.pmem_resp; eb = 1'b1;
    end
    chk("pmem_read", bus.pmem_read, er);
    chk("pmem_write", bus.pmem_write, ew);
    chk("pmem_addr", bus.pmem_addr, ea);
    chk("pmem_wdata", bus.pmem_wdata, ed);
    chk("i_resp", bus.i_resp, eir);
    chk("d_resp", bus.d_resp, edr);
    chk("busy", bus.busy, eb);
    chk("i_rdata", bus.i_rdata, bus.pmem_rdata);
    chk("d_rdata", bus.d_rdata, bus.pmem_rdata);
  endtask

  task automatic mem_fire();
    bus.pmem_resp = 1'b1;
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      bus.pmem_rdata = {8{$urandom}};
    end else begin
      bus.pmem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr);
    end
    mem_pend = 1'b0;
  endtask

  // one clock cycle: check, advance model, then drive memory and requesters
  task automatic step();
    bit ir, dr, take_d;
    @(negedge clk);
    compare();
    if (bus.pmem_read) n_pread++;
    if (bus.i_resp) begin
      n_iresp++;
      rsp_log.push_back('{who: 0, wr: bus.pmem_write, wdata: bus.pmem_wdata, rdata: bus.i_rdata});
    end
    if (bus.d_resp) begin
      n_dresp++;
      rsp_log.push_back('{who: 1, wr: bus.pmem_write, wdata: bus.pmem_wdata, rdata: bus.d_rdata});
    end
    s_i = bus.i_resp; s_d = bus.d_resp;
    s_cmd = bus.pmem_read | bus.pmem_write; s_wr = bus.pmem_write;
    s_addr = bus.pmem_addr; s_wdata = bus.pmem_wdata;

    @(posedge clk);
    if (reset) begin
      owner = 0; last_d = 1'b0;
    end else if (owner == 0) begin
      ir = bus.i_read;
      dr = bus.d_read | bus.d_write;
`ifdef ARB_RR_EN
      take_d = (ir && dr) ? !last_d : dr;
`else
      take_d = dr;
`endif
      if (ir || dr) begin
        owner = take_d ? 2 : 1;
        last_d = take_d;
        grant_log.push_back(owner);
      end
    end else if (bus.pmem_resp) begin
      owner = 0;
    end

    #1;
    if (!reset) begin
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = {8{$urandom}};
      end else if (stray_n > 0 && !mem_pend) begin
        stray_n--;
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = {8{$urandom}};
      end else if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) mem_fire();
      end else if (s_cmd) begin
        mem_pend = 1'b1;
        mem_addr = s_addr; mem_wr = s_wr; mem_wdata = s_wdata;
        mem_cnt = (lat_rand ? int'($urandom_range(1, 6)) : 5) - 1;
        if (mem_cnt == 0) mem_fire();
      end

      if (bus.i_read && s_i) bus.i_read = 1'b0;
      if (!bus.i_read && i_q.size() > 0) begin
        bus.i_read = 1'b1;
        bus.i_addr = i_q.pop_front();
      end
      if ((bus.d_read || bus.d_write) && s_d) begin
        bus.d_read = 1'b0; bus.d_write = 1'b0;
      end
      if (!bus.d_read && !bus.d_write && d_q.size() > 0) begin
        dop_t op;
        op = d_q.pop_front();
        bus.d_read = op.rd; bus.d_write = op.wr;
        bus.d_addr = op.addr; bus.d_wdata = op.wdata;
      end
    end
  endtask

  task automatic wait_rsp(input int n, input string name);
    int budget;
    budget = 200;
    while (rsp_log.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (rsp_log.size() < n) timeout(name);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    owner = 0; last_d = 1'b0;
    mem_pend = 1'b0; bus.pmem_resp = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    i_q.delete(); d_q.delete();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    rsp_log.delete(); grant_log.delete();
    n_pread = 0; n_iresp = 0; n_dresp = 0;
  endtask

  initial begin
    int exp_who[10];
    int base_i, base_d;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    #1 reset = 1'b1;
    repeat (2) step();
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_i_resp", bus.i_resp, 1'b0);
    reset = 1'b0;
    step();

    // single I read, memory latency 5
    clear_logs();
    i_q.push_back(32'h0000_0040);
    wait_rsp(1, "single_i");
    repeat (2) step();
    chk("single_i_pread_cycles", n_pread, 6);
    chk("single_i_resp_count", n_iresp, 1);
    chk("single_i_d_resp_count", n_dresp, 0);
    chk("single_i_rdata", rsp_log[0].rdata, {8{32'hC0DE_0040}});

    // D writeback then read back the same line
    clear_logs();
    d_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h8000_0020, wdata: {8{32'hDEAD_BEEF}}});
    d_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h8000_0020, wdata: '0});
    wait_rsp(2, "d_wb_rd");
    repeat (2) step();
    chk("d_wb_first_is_write", rsp_log[0].wr, 1'b1);
    chk("d_wb_wdata", rsp_log[0].wdata, {8{32'hDEAD_BEEF}});
    chk("d_rd_second_is_read", rsp_log[1].wr, 1'b0);
    chk("d_rd_rdata", rsp_log[1].rdata, {8{32'hDEAD_BEEF}});
    chk("d_wb_i_resp_count", n_iresp, 0);

    // stray completion with nothing granted
    clear_logs();
    stray_n = 1;
    repeat (4) step();
    chk("stray_resp_count", n_iresp + n_dresp, 0);
    chk("stray_busy", bus.busy, 1'b0);
    chk("stray_grants", grant_log.size(), 0);

    // reset two cycles into an I grant
    clear_logs();
    i_q.push_back(32'h0000_0100);
    for (int k = 0; k < 20 && owner != 1; k++) step();
    repeat (2) step();
    reset = 1'b1;
    owner = 0; last_d = 1'b0;
    #1;
    chk("midrst_pmem_read", bus.pmem_read, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    apply_reset();
    step();
    chk("midrst_no_i_resp", n_iresp, 0);
    i_q.push_back(32'h0000_0140);
    wait_rsp(1, "after_reset");
    chk("after_reset_rdata", rsp_log[0].rdata, {8{32'hC0DE_0140}});
    chk("after_reset_who", rsp_log[0].who, 0);

    // simultaneous requests, twice
    apply_reset();
    clear_logs();
    i_q.push_back(32'h0000_0200);
    d_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0240, wdata: '0});
    wait_rsp(2, "tie1");
    chk("tie1_first", rsp_log[0].who, 1);
    chk("tie1_second", rsp_log[1].who, 0);
    chk("tie1_model_first", grant_log[0], 2);
    i_q.push_back(32'h0000_0280);
    d_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_02C0, wdata: '0});
    wait_rsp(4, "tie2");
    chk("tie2_first", rsp_log[2].who, 1);
    chk("tie2_second", rsp_log[3].who, 0);

    // continuous contention for 10 transactions
    apply_reset();
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      i_q.push_back(32'h0000_1000 + 32'(k * 32));
      d_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_2000 + 32'(k * 32), wdata: '0});
    end
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_RR_EN
      exp_who[k] = (k % 2 == 0) ? 1 : 0;
`else
      exp_who[k] = (k < 5) ? 1 : 0;
`endif
    end
    wait_rsp(10, "contend");
    for (int k = 0; k < 10; k++) chk($sformatf("contend_%0d", k), rsp_log[k].who, exp_who[k]);

    // randomized traffic
    repeat (4) step();
    clear_logs();
    lat_rand = 1'b1;
    base_i = 0; base_d = 0;
    for (int c = 0; c < 600; c++) begin
      if (i_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        i_q.push_back(32'($urandom_range(0, 7)) << 5);
        base_i++;
      end
      if (d_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, 3);
        d_q.push_back('{rd: (r == 1 || r == 2), wr: (r != 1),
                        addr: 32'($urandom_range(0, 7)) << 5,
                        wdata: {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom}});
        base_d++;
      end
      step();
    end
    for (int k = 0; k < 400 && (i_q.size() > 0 || d_q.size() > 0 || bus.busy
                                 || bus.i_read || bus.d_read || bus.d_write); k++) step();
    repeat (3) step();
    chk("random_all_served", rsp_log.size(), base_i + base_d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
